// File: rtl/cast_pkg.sv
// Shared types and helpers for the multicast fabric: flit type encoding,
// arbiter state encoding, default geometry and node indexing.
package cast_pkg;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam int CAST_NOC_W   = 3;
    localparam int CAST_NOC_H   = 3;
    localparam int CAST_DW      = 32;
    localparam int CAST_CREDITS = 4;

    // Field positions for the default flit width.
    localparam int TYPE_HI = CAST_DW - 1;
    localparam int TYPE_LO = CAST_DW - 2;
    localparam int MASK_W  = CAST_NOC_W * CAST_NOC_H;

    function automatic int node_idx(input int x, input int y, input int w);
        return x + y * w;
    endfunction

    // HEAD and SINGLE open a packet and carry a destination mask.
    function automatic logic is_head_like(input flit_type_e t);
        return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
    endfunction

endpackage

// File: rtl/cast_eject_port.sv
// One eject port: a single-entry output register with valid/ready hold
// semantics and a credit counter tracking free slots in the consumer.
module cast_eject_port
    import cast_pkg::*;
#(
    parameter int DW           = CAST_DW,
    parameter int CREDIT_DEPTH = CAST_CREDITS
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          ready_i,
    input  logic          credit_upd,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic          can_accept
);

    localparam int CW = $clog2(CREDIT_DEPTH + 1);
    localparam logic [CW-1:0] CMAX = CW'(CREDIT_DEPTH);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic [CW-1:0] credit_q, credit_d;

    // Output register: hold until handshake, a same-cycle reload wins.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && ready_i) valid_d = 1'b0;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end
    end

    // Credits: spend on load, refund on credit_upd, saturate at the buffer depth.
    always_comb begin
        credit_d = credit_q;
        if (load && !credit_upd)
            credit_d = credit_q - 1'b1;
        else if (!load && credit_upd && credit_q != CMAX)
            credit_d = credit_q + 1'b1;
    end

    assign can_accept = (!valid_q || ready_i) && (credit_q != '0);
    assign valid_o    = valid_q;
    assign data_o     = data_q;

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rstn) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            credit_q <= CMAX;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            credit_q <= credit_d;
        end
    end

endmodule

// File: rtl/cast_mesh_fabric.sv
// Multicast packet fabric: round-robin packet arbiter over all inject ports,
// replicating each granted flit in lockstep into every destination eject port.
// Optional CAST_SRC_EXCLUDE_EN: clear the source's own bit from the mask so a
// node never receives its own packets.
module cast_mesh_fabric
    import cast_pkg::*;
#(
    parameter int NOC_WIDTH    = CAST_NOC_W,
    parameter int NOC_HEIGHT   = CAST_NOC_H,
    parameter int DW           = CAST_DW,
    parameter int CREDIT_DEPTH = CAST_CREDITS
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic [NOC_WIDTH*NOC_HEIGHT*DW-1:0] data_i,
    input  logic [NOC_WIDTH*NOC_HEIGHT-1:0]    valid_i,
    output logic [NOC_WIDTH*NOC_HEIGHT-1:0]    ready_o,
    output logic [NOC_WIDTH*NOC_HEIGHT*DW-1:0] data_o,
    output logic [NOC_WIDTH*NOC_HEIGHT-1:0]    valid_o,
    input  logic [NOC_WIDTH*NOC_HEIGHT-1:0]    ready_i,
    input  logic [NOC_WIDTH*NOC_HEIGHT-1:0]    credit_upd
);

    // Index of the node just past the last row is the node count.
    localparam int N  = node_idx(0, NOC_HEIGHT, NOC_WIDTH);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    arb_state_e    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  mask_q, mask_d;

    logic [N-1:0][DW-1:0] flit_in;
    logic [N-1:0][DW-1:0] eject_data;
    logic [N-1:0]         can_accept;
    logic [N-1:0]         load;

    logic          found;
    logic [IW-1:0] winner;
    logic [IW:0]   scan_sum;
    logic [IW-1:0] src;
    logic          has_flit;
    logic [DW-1:0] flit;
    flit_type_e    ftype;
    logic [N-1:0]  dest;
    logic          fire;
    logic [IW:0]   ptr_nxt;

    assign flit_in = data_i;
    assign data_o  = eject_data;

    // Round-robin search for the first HEAD/SINGLE at or after the pointer.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_sum = '0;
        for (int k = 0; k < N; k++) begin
            scan_sum = {1'b0, ptr_q} + (IW+1)'(k);
            if (scan_sum >= (IW+1)'(N)) scan_sum = scan_sum - (IW+1)'(N);
            if (!found && valid_i[scan_sum[IW-1:0]] &&
                is_head_like(flit_type_e'(flit_in[scan_sum[IW-1:0]][DW-1:DW-2]))) begin
                found  = 1'b1;
                winner = scan_sum[IW-1:0];
            end
        end
    end

    // Grant, transfer check, replication enables and arbiter next state.
    always_comb begin
        src      = (state_q == ARB_IDLE) ? winner : owner_q;
        has_flit = (state_q == ARB_IDLE) ? found : valid_i[owner_q];
        flit     = flit_in[src];
        ftype    = flit_type_e'(flit[DW-1:DW-2]);
        dest     = is_head_like(ftype) ? flit[N-1:0] : mask_q;
`ifdef CAST_SRC_EXCLUDE_EN
        dest[src] = 1'b0;
`endif
        // Whole packet moves in lockstep: every destination must take it now.
        fire = has_flit && (&(can_accept | ~dest)) && !rstn;

        ready_o = '0;
        if (!rstn && state_q == ARB_IDLE) begin
            // Orphan BODY/TAIL with no open packet are swallowed.
            for (int n = 0; n < N; n++)
                if (valid_i[n] && !is_head_like(flit_type_e'(flit_in[n][DW-1:DW-2])))
                    ready_o[n] = 1'b1;
        end
        if (fire) ready_o[src] = 1'b1;

        load = fire ? dest : '0;

        ptr_nxt = {1'b0, winner} + 1'b1;
        if (ptr_nxt == (IW+1)'(N)) ptr_nxt = '0;

        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        mask_d  = mask_q;
        if (fire) begin
            if (state_q == ARB_IDLE) begin
                ptr_d = ptr_nxt[IW-1:0];
                if (ftype == FLIT_HEAD) begin
                    state_d = ARB_LOCKED;
                    owner_d = winner;
                    mask_d  = dest;
                end
            end else if (ftype == FLIT_TAIL || ftype == FLIT_SINGLE) begin
                state_d = ARB_IDLE;
            end else if (ftype == FLIT_HEAD) begin
                mask_d = dest;
            end
        end
    end

    // Arbiter registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            mask_q  <= mask_d;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_port
        cast_eject_port #(
            .DW           (DW),
            .CREDIT_DEPTH (CREDIT_DEPTH)
        ) u_port (
            .clk        (clk),
            .rstn       (rstn),
            .load       (load[g]),
            .load_data  (flit),
            .ready_i    (ready_i[g]),
            .credit_upd (credit_upd[g]),
            .valid_o    (valid_o[g]),
            .data_o     (eject_data[g]),
            .can_accept (can_accept[g])
        );
    end

endmodule

// File: tb/tb_cast_mesh_fabric.sv
// Randomized scoreboard bench for cast_mesh_fabric with a packet-level model.
module tb_cast_mesh_fabric;
    import cast_pkg::*;

    localparam int N  = 9;
    localparam int DW = 32;
    localparam int CD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstn;
    logic [N*DW-1:0] data_i;
    logic [N-1:0]    valid_i, ready_o, valid_o, ready_i, credit_upd;
    logic [N*DW-1:0] data_o;

    cast_mesh_fabric #(.NOC_WIDTH(3), .NOC_HEIGHT(3), .DW(DW), .CREDIT_DEPTH(CD)) dut (
        .clk(clk), .rstn(rstn), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .credit_upd(credit_upd)
    );

    typedef struct { logic [DW-1:0] data; int due; } exp_t;
    exp_t exp_q[N][$];

    int n_checks = 0, n_fail = 0, n_eject = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // stimulus knobs
    logic [N-1:0] src_en;
    int p_ready, p_credit, p_idle;
    bit in_pkt[N];
    int body_left[N];

    // model state
    bit           m_locked;
    int           m_owner, m_ptr;
    logic [N-1:0] m_mask;
    int           m_cred[N];
    bit           m_occ[N];
    logic [N-1:0] exp_ready;

    function automatic logic [1:0] type_of(input logic [DW-1:0] f);
        return f[DW-1:DW-2];
    endfunction

    function automatic logic [DW-1:0] next_flit(input int n);
        logic [DW-1:0] f;
        logic [N-1:0]  m;
        int r;
        f = $urandom;
        r = $urandom_range(0, 7);
        case (r)
            0: m = '0;
            1: m = N'(1) << n;
            2: m = '1;
            default: m = N'($urandom);
        endcase
        if (in_pkt[n]) begin
            if (body_left[n] > 0) begin f[DW-1:DW-2] = FLIT_BODY; body_left[n]--; end
            else begin f[DW-1:DW-2] = FLIT_TAIL; in_pkt[n] = 0; end
        end else begin
            r = $urandom_range(0, 9);
            if (r == 0) f[DW-1:DW-2] = ($urandom_range(0, 1) == 1) ? FLIT_TAIL : FLIT_BODY;
            else if (r < 4) begin f[DW-1:DW-2] = FLIT_SINGLE; f[N-1:0] = m; end
            else begin
                f[DW-1:DW-2] = FLIT_HEAD; f[N-1:0] = m;
                in_pkt[n] = 1; body_left[n] = $urandom_range(0, 3);
            end
        end
        return f;
    endfunction

    // Monitor: compare each eject port against the expected queue.
    always @(negedge clk) begin
        for (int d = 0; d < N; d++) begin
            logic [DW-1:0] got;
            got = data_o[d*DW +: DW];
            n_checks++;
            if (exp_q[d].size() > 0 && exp_q[d][0].due <= cyc) begin
                if (valid_o[d] !== 1'b1 || got !== exp_q[d][0].data) begin
                    n_fail++;
                    $display("FAIL eject[%0d] cyc %0d: valid_o=%b data_o=%h, required valid_o=1 data_o=%h",
                             d, cyc, valid_o[d], got, exp_q[d][0].data);
                end
                if (valid_o[d] && ready_i[d]) begin
                    void'(exp_q[d].pop_front());
                    n_eject++;
                end
            end else if (valid_o[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL spurious[%0d] cyc %0d: valid_o=%b data_o=%h, required valid_o=0",
                         d, cyc, valid_o[d], got);
            end
        end
    end

    // Reference model: derive grant and deliveries from the fabric rules.
    always @(negedge clk) begin
        int src;
        bit fire;
        logic [DW-1:0] f;
        logic [1:0] t;
        logic [N-1:0] dm;
        #1;
        if (rstn) begin
            m_locked = 0; m_owner = 0; m_ptr = 0; m_mask = '0;
            for (int d = 0; d < N; d++) begin m_cred[d] = CD; m_occ[d] = 0; exp_q[d].delete(); end
            n_checks++;
            if (ready_o !== '0) begin
                n_fail++;
                $display("FAIL ready_in_reset cyc %0d: ready_o=%b, required 0", cyc, ready_o);
            end
        end else begin
            exp_ready = '0; src = -1; fire = 0; f = '0; t = 2'b00; dm = '0;
            if (!m_locked) begin
                for (int n = 0; n < N; n++) begin
                    t = type_of(data_i[n*DW +: DW]);
                    if (valid_i[n] && (t == FLIT_BODY || t == FLIT_TAIL)) exp_ready[n] = 1'b1;
                end
                for (int k = 0; k < N; k++) begin
                    int n;
                    n = (m_ptr + k) % N;
                    t = type_of(data_i[n*DW +: DW]);
                    if (src < 0 && valid_i[n] && (t == FLIT_HEAD || t == FLIT_SINGLE)) src = n;
                end
            end else if (valid_i[m_owner]) src = m_owner;
            if (src >= 0) begin
                f  = data_i[src*DW +: DW];
                t  = type_of(f);
                dm = (t == FLIT_HEAD || t == FLIT_SINGLE) ? f[N-1:0] : m_mask;
`ifdef CAST_SRC_EXCLUDE_EN
                dm[src] = 1'b0;
`endif
                fire = 1;
                for (int d = 0; d < N; d++)
                    if (dm[d] && ((m_occ[d] && !ready_i[d]) || m_cred[d] == 0)) fire = 0;
                if (fire) exp_ready[src] = 1'b1;
            end
            n_checks++;
            if (ready_o !== exp_ready) begin
                n_fail++;
                $display("FAIL ready_o cyc %0d: got %b, required %b", cyc, ready_o, exp_ready);
            end
            for (int d = 0; d < N; d++) begin
                bit ld;
                exp_t e;
                ld = fire && dm[d];
                if (ld) begin
                    e.data = f; e.due = cyc + 1;
                    exp_q[d].push_back(e);
                    m_occ[d] = 1;
                end else if (ready_i[d]) m_occ[d] = 0;
                if (ld && !credit_upd[d]) m_cred[d]--;
                else if (!ld && credit_upd[d] && m_cred[d] < CD) m_cred[d]++;
            end
            if (fire) begin
                if (!m_locked) begin
                    m_ptr = (src + 1) % N;
                    if (t == FLIT_HEAD) begin m_locked = 1; m_owner = src; m_mask = dm; end
                end else if (t == FLIT_TAIL || t == FLIT_SINGLE) m_locked = 0;
                else if (t == FLIT_HEAD) m_mask = dm;
            end
        end
    end

    // Driver: hold each flit until its handshake, then present the next one.
    initial begin
        logic [N-1:0] hs;
        valid_i = '0; data_i = '0; ready_i = '1; credit_upd = '0;
        for (int n = 0; n < N; n++) begin in_pkt[n] = 0; body_left[n] = 0; end
        forever begin
            @(negedge clk);
            hs = valid_i & ready_o;
            @(posedge clk);
            #1;
            for (int n = 0; n < N; n++) begin
                if (!valid_i[n] || hs[n]) begin
                    if (in_pkt[n] || (src_en[n] && $urandom_range(0, 99) >= p_idle)) begin
                        valid_i[n] = 1'b1;
                        data_i[n*DW +: DW] = next_flit(n);
                    end else valid_i[n] = 1'b0;
                end
            end
            for (int d = 0; d < N; d++) begin
                ready_i[d]    = ($urandom_range(0, 99) < p_ready);
                credit_upd[d] = ($urandom_range(0, 99) < p_credit);
            end
        end
    end

    task automatic run(input logic [N-1:0] en, input int pr, input int pc, input int pi, input int cycles);
        src_en = en; p_ready = pr; p_credit = pc; p_idle = pi;
        repeat (cycles) @(posedge clk);
    endtask

    initial begin
        rstn = 1'b1;
        src_en = '0; p_ready = 100; p_credit = 0; p_idle = 100;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (valid_o !== '0 || data_o !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid_o=%b data_o=%h, required all zero", valid_o, data_o);
        end
        @(posedge clk); #1;
        rstn = 1'b0;
        run(9'b000000100, 100, 50, 30, 60);    // single source, free-flowing
        run(9'b000000100, 60, 50, 20, 100);    // single source, eject stalls
        run(9'b000010001, 90, 60, 10, 150);    // nodes 0 and 4 contend
        run(9'b000010001, 90, 0, 0, 40);       // credit starvation
        run(9'b000010001, 90, 60, 0, 40);      // credits return
        run('1, 60, 50, 30, 400);              // all sources with orphans
        #1 rstn = 1'b1;                        // reset mid-traffic
        repeat (2) @(posedge clk);
        #1 rstn = 1'b0;
        run('1, 75, 60, 20, 250);
        src_en = '0;
        repeat (5) @(posedge clk);
        n_checks++;
        if (n_eject < 100) begin
            n_fail++;
            $display("FAIL eject_activity: %0d ejected flits, required at least 100", n_eject);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
